// File: rtl/proj_pkg.sv
// Shared types and constants for the projection extender stream.
package proj_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int BASE_LEN       = 2;
    localparam int ONE_HOT_LEN    = 4;
    localparam int DEF_FRAG_LEN   = 128;
    localparam int DEF_KMER_LEN   = 16;
    localparam int DEF_PART_BASES = 16;

endpackage

// File: rtl/proj_base_onehot.sv
// Combinational encoder: each 2-bit base becomes a 4-bit one-hot nibble
// (00->0001, 01->0010, 10->0100, 11->1000).
module proj_base_onehot
    import proj_pkg::*;
#(
    parameter int PART_BASES = DEF_PART_BASES
) (
    input  logic [PART_BASES*BASE_LEN-1:0]    i_bases,
    output logic [PART_BASES*ONE_HOT_LEN-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int b = 0; b < PART_BASES; b++) begin
            o_onehot[b*ONE_HOT_LEN +: ONE_HOT_LEN] =
                ONE_HOT_LEN'(1) << i_bases[b*BASE_LEN +: BASE_LEN];
        end
    end

endmodule

// File: rtl/proj_extender_stream.sv
// Streams a captured fragment as one-hot parts once per k-mer index of a batch.
// Optional macro PROJ_EXTENDER_CLAMP_EN saturates negative out_index to 0.
module proj_extender_stream
    import proj_pkg::*;
#(
    parameter  int FRAG_LEN          = DEF_FRAG_LEN,
    parameter  int KMER_LEN          = DEF_KMER_LEN,
    parameter  int INDICES_COUNT     = 8,
    parameter  int INDICE_LEN        = 8,
    parameter  int PART_BASES        = DEF_PART_BASES,
    localparam int PARTS             = FRAG_LEN / PART_BASES,
    localparam int SIGNED_INDICE_LEN = INDICE_LEN + 1,
    localparam int CNT_W             = $clog2(INDICES_COUNT + 1),
    localparam int OFFSET            = (FRAG_LEN - KMER_LEN) >> 1,
    localparam int PART_W            = (PARTS > 1) ? $clog2(PARTS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FRAG_LEN*BASE_LEN-1:0]        in_fragment,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_kmer_indices,
    input  logic [CNT_W-1:0]                    in_count,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SIGNED_INDICE_LEN-1:0]        out_index,
    output logic [PART_BASES*ONE_HOT_LEN-1:0]   out_gfm,
    output logic [PART_W-1:0]                   out_part_idx,
    output logic                                out_first,
    output logic                                out_last
);

    localparam int                           PART_BITS = PART_BASES * BASE_LEN;
    localparam logic [SIGNED_INDICE_LEN-1:0] OFFSET_S  = SIGNED_INDICE_LEN'(OFFSET);
    localparam logic [CNT_W-1:0]             MAX_CNT   = CNT_W'(INDICES_COUNT);
    localparam logic [PART_W-1:0]            LAST_PART = PART_W'(PARTS - 1);

    state_t                              r_state;
    state_t                              w_state_next;
    logic [FRAG_LEN*BASE_LEN-1:0]        r_frag;
    logic [INDICES_COUNT*INDICE_LEN-1:0] r_indices;
    logic [CNT_W-1:0]                    r_count;
    logic [CNT_W-1:0]                    r_idx;
    logic [PART_W-1:0]                   r_part;

    logic                                w_streaming;
    logic                                w_last_beat;
    logic                                w_accept;
    logic                                w_load;
    logic [CNT_W-1:0]                    w_count;
    logic [INDICE_LEN-1:0]               w_sel_index;
    logic [SIGNED_INDICE_LEN-1:0]        w_raw_index;
    logic [SIGNED_INDICE_LEN-1:0]        w_index;
    logic [PART_BASES*ONE_HOT_LEN-1:0]   w_gfm;

    assign w_streaming = (r_state == STREAM);
    assign w_last_beat = w_streaming && (r_idx == r_count - CNT_W'(1)) && (r_part == LAST_PART);
    assign w_count     = (in_count > MAX_CNT) ? MAX_CNT : in_count;

    // NOTE: in_ready depends combinationally on out_ready so the next batch can
    // load during the final beat's handshake without an idle cycle.
    assign in_ready = (r_state == IDLE) || (w_last_beat && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && (w_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = STREAM;
            STREAM: begin
                if (w_accept)                      w_state_next = w_load ? STREAM : IDLE;
                else if (w_last_beat && out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: the captured fragment and indices are ordinary flops here, so they
    // take the async reset like every other register rather than being left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frag    <= '0;
            r_indices <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_part    <= '0;
        end else if (w_load) begin
            r_frag    <= in_fragment;
            r_indices <= in_kmer_indices;
            r_count   <= w_count;
            r_idx     <= '0;
            r_part    <= '0;
        end else if (w_streaming && out_ready) begin
            if (r_part == LAST_PART) begin
                r_part <= '0;
                r_idx  <= r_idx + CNT_W'(1);
            end else begin
                r_part <= r_part + PART_W'(1);
            end
        end
    end

    assign w_sel_index = r_indices[r_idx*INDICE_LEN +: INDICE_LEN];
    assign w_raw_index = {1'b0, w_sel_index} - OFFSET_S;

`ifdef PROJ_EXTENDER_CLAMP_EN
    assign w_index = w_raw_index[SIGNED_INDICE_LEN-1] ? '0 : w_raw_index;
`else
    assign w_index = w_raw_index;
`endif

    proj_base_onehot #(
        .PART_BASES (PART_BASES)
    ) u_onehot (
        .i_bases  (r_frag[r_part*PART_BITS +: PART_BITS]),
        .o_onehot (w_gfm)
    );

    // Beat fields come straight from registers, so they hold while stalled.
    assign out_valid    = w_streaming;
    assign out_index    = w_streaming ? w_index : '0;
    assign out_gfm      = w_streaming ? w_gfm : '0;
    assign out_part_idx = w_streaming ? r_part : '0;
    assign out_first    = w_streaming && (r_part == '0);
    assign out_last     = w_last_beat;

endmodule
